key_xlate_arbiter: RTL and testbench
====================================

KEY_XLATE_ARBITER -- requirements
Module: key_xlate_arbiter

Interface
REQ-001 The module SHALL have parameter N_REQ, default 4, meaning the number of requesters (2..8).
REQ-002 The module SHALL have parameter TIMEOUT, default 1024, meaning the maximum WAIT cycles before a call is abandoned.
REQ-003 Port clock, input, 1, SHALL be the single clock; all logic is rising-edge.
REQ-004 Port resetn, input, 1, SHALL be the reset: asynchronous, active-low.
REQ-005 Port req_valid, input, N_REQ, SHALL flag a pending request per requester.
REQ-006 Port req_code, input, 32*N_REQ, SHALL carry the virtual keycode per requester, slice i = [32i+31:32i].
REQ-007 Port req_ready, output, N_REQ, SHALL be a one-hot, one-cycle pulse that accepts the granted request.
REQ-008 Port resp_valid, output, N_REQ, SHALL be one-hot and held until that requester's resp_ready.
REQ-009 Port resp_ready, input, N_REQ, SHALL be the per-requester response acceptance.
REQ-010 Port resp_data, output, 32, SHALL be the translated key code, shared by all requesters.
REQ-011 Port resp_err, output, 1, SHALL be high with resp_valid when the call timed out.
REQ-012 Port comp_start, output, 1, SHALL drive the translator's call.valid.
REQ-013 Port comp_busy, input, 1, SHALL be the translator's call.stall.
REQ-014 Port comp_code, output, 32, SHALL drive the translator's code argument.
REQ-015 Port comp_done, input, 1, SHALL be the translator's return.valid.
REQ-016 Port comp_stall, output, 1, SHALL drive the translator's return.stall.
REQ-017 Port comp_returndata, input, 32, SHALL be the translator's returndata.
REQ-018 Port stat_calls, output, 16, SHALL count completed (non-timeout) calls.
REQ-019 Port stat_timeouts, output, 8, SHALL count timeouts, saturating at 255.
REQ-020 Port stat_late, output, 8, SHALL count discarded comp_done pulses, saturating at 255.

Function
REQ-021 The FSM SHALL have the states IDLE, CALL, WAIT, RESP; there SHALL be at most one outstanding translator call.
REQ-022 IDLE: when any req_valid bit is set, the FSM SHALL grant the lowest index at or above (last_grant+1) mod N_REQ, pulse req_ready[g], latch g and req_code[g], and go to CALL.
REQ-023 last_grant SHALL reset to N_REQ-1, so requester 0 wins first; it SHALL update only on a grant.
REQ-024 CALL: comp_start=1 and comp_code=latched code; a cycle with comp_busy=0 SHALL be the call acceptance, and the FSM SHALL go to WAIT next cycle with the timeout counter cleared.
REQ-025 comp_stall SHALL be 0 only in WAIT and 1 in every other state.
REQ-026 WAIT: comp_done=1 SHALL latch comp_returndata, clear resp_err, increment stat_calls (wrapping), and go to RESP.
REQ-027 WAIT: when the counter reaches TIMEOUT-1 without comp_done, the FSM SHALL set resp_data=0 and resp_err=1, increment stat_timeouts, and go to RESP.
REQ-028 comp_done=1 in IDLE, CALL or RESP SHALL be discarded and increment stat_late.
REQ-029 RESP: resp_valid[g]=1 SHALL hold until resp_ready[g]=1, then the FSM SHALL go to IDLE; resp_ready on other bits SHALL be ignored.
REQ-030 A request SHALL NOT be granted in the same cycle as a RESP completion; minimum turnaround is IDLE->CALL->WAIT->RESP->IDLE (4 cycles with a zero-latency translator).
REQ-031 req_valid deassertion after acceptance SHALL NOT affect an in-flight call.

Reset
REQ-032 resetn low SHALL asynchronously force IDLE, every output to 0 except comp_stall=1, all counters to 0, last_grant=N_REQ-1.
REQ-033 Reset asserted mid-call SHALL abandon the call without a response; a post-reset comp_done SHALL count in stat_late.

Verification
REQ-034 The bench SHALL cover: req_valid=0001, code 0x31, translator returns 0x0A after 3 cycles -> req_ready[0] pulse, resp_valid=0001, resp_data=0x0A, stat_calls=1.
REQ-035 The bench SHALL cover: req_valid=1111 held for 8 calls -> grant order 0,1,2,3,0,1,2,3.
REQ-036 The bench SHALL cover: comp_busy=1 for 5 cycles in CALL -> comp_start held 6 cycles, comp_code stable, one call only.
REQ-037 The bench SHALL cover: TIMEOUT=16, translator never returns -> RESP after 16 WAIT cycles, resp_err=1, resp_data=0, stat_timeouts=1; a later comp_done -> stat_late=1.
REQ-038 The bench SHALL cover: resp_ready held low 10 cycles -> resp_valid and resp_data stable, no new req_ready.
REQ-039 The bench SHALL cover: resetn low during WAIT -> immediate IDLE, outputs at reset values, no resp_valid.

Source files
------------

// File: rtl/key_xlate_arbiter.sv
// Round-robin arbiter that funnels N_REQ keycode-translation requesters onto a
// single translator call port, with one call outstanding at a time, a WAIT
// timeout, and saturating/wrapping statistics counters.
module key_xlate_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [32*N_REQ-1:0]  req_code,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     resp_valid,
    input  logic [N_REQ-1:0]     resp_ready,
    output logic [31:0]          resp_data,
    output logic                 resp_err,
    output logic                 comp_start,
    input  logic                 comp_busy,
    output logic [31:0]          comp_code,
    input  logic                 comp_done,
    output logic                 comp_stall,
    input  logic [31:0]          comp_returndata,
    output logic [15:0]          stat_calls,
    output logic [7:0]           stat_timeouts,
    output logic [7:0]           stat_late
);

    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALL = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]       r_state;
    logic [GW-1:0]    r_last;
    logic [GW-1:0]    r_gnt;
    logic [31:0]      r_code;
    logic [CW-1:0]    r_cnt;
    logic [N_REQ-1:0] r_req_ready;
    logic [31:0]      r_resp_data;
    logic             r_resp_err;
    logic [15:0]      r_calls;
    logic [7:0]       r_timeouts;
    logic [7:0]       r_late;

    logic             w_any;
    logic             w_found;
    logic [GW-1:0]    w_gnt;
    logic [N_REQ-1:0] w_gnt_oh;
    logic [31:0]      w_gnt_code;
    logic [N_REQ-1:0] w_resp_valid;
    logic             w_resp_fire;
    logic             w_done;
    logic             w_timeout;
    logic             w_late;

    // Round-robin pick: lowest requester above last_grant, else wrap to lowest overall.
    always_comb begin
        w_any      = |req_valid;
        w_found    = 1'b0;
        w_gnt      = '0;
        w_gnt_oh   = '0;
        w_gnt_code = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && req_valid[i] && (GW'(i) > r_last)) begin
                w_found = 1'b1;
                w_gnt   = GW'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && req_valid[i]) begin
                w_found = 1'b1;
                w_gnt   = GW'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (GW'(i) == w_gnt) begin
                w_gnt_oh[i] = 1'b1;
                w_gnt_code  = req_code[32*i +: 32];
            end
        end
    end

    // Response strobe is the latched grant decoded one-hot, only while in RESP.
    always_comb begin
        w_resp_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_resp_valid[i] = (r_state == S_RESP) && (GW'(i) == r_gnt);
        end
        // Only the granted requester's ready bit can close the response.
        w_resp_fire = |(w_resp_valid & resp_ready);
    end

    assign w_done    = (r_state == S_WAIT) && comp_done;
    assign w_timeout = (r_state == S_WAIT) && !comp_done && (r_cnt == CW'(TIMEOUT - 1));
    assign w_late    = (r_state != S_WAIT) && comp_done;

    // Main call-sequencing FSM: grant, issue call, wait for return or timeout, respond.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_last      <= GW'(N_REQ - 1);
            r_gnt       <= '0;
            r_code      <= '0;
            r_cnt       <= '0;
            r_req_ready <= '0;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
        end else begin
            r_req_ready <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state     <= S_CALL;
                        r_gnt       <= w_gnt;
                        r_last      <= w_gnt;
                        r_code      <= w_gnt_code;
                        r_req_ready <= w_gnt_oh;
                    end
                end
                S_CALL: begin
                    if (!comp_busy) begin
                        r_state <= S_WAIT;
                        r_cnt   <= '0;
                    end
                end
                S_WAIT: begin
                    if (comp_done) begin
                        r_resp_data <= comp_returndata;
                        r_resp_err  <= 1'b0;
                        r_state     <= S_RESP;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_resp_data <= '0;
                        r_resp_err  <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (w_resp_fire) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Statistics: completed calls wrap, timeouts and stray returns saturate.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_calls    <= '0;
            r_timeouts <= '0;
            r_late     <= '0;
        end else begin
            if (w_done) begin
                r_calls <= r_calls + 16'd1;
            end
            if (w_timeout && (r_timeouts != 8'hFF)) begin
                r_timeouts <= r_timeouts + 8'd1;
            end
            if (w_late && (r_late != 8'hFF)) begin
                r_late <= r_late + 8'd1;
            end
        end
    end

    assign req_ready     = r_req_ready;
    assign resp_valid    = w_resp_valid;
    assign resp_data     = r_resp_data;
    assign resp_err      = r_resp_err;
    assign comp_start    = (r_state == S_CALL);
    assign comp_code     = (r_state == S_CALL) ? r_code : 32'd0;
    // Return channel is only open while a call is outstanding.
    assign comp_stall    = (r_state != S_WAIT);
    assign stat_calls    = r_calls;
    assign stat_timeouts = r_timeouts;
    assign stat_late     = r_late;

endmodule

// File: tb/tb_key_xlate_arbiter.sv
// Directed bench for key_xlate_arbiter with a behavioural translator, a
// round-robin grant model and a response scoreboard.
module tb_key_xlate_arbiter;

    localparam int NR = 4;

    logic              clock = 1'b0;
    logic              resetn;
    logic [NR-1:0]     req_valid;
    logic [32*NR-1:0]  req_code;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     resp_valid;
    logic [NR-1:0]     resp_ready;
    logic [31:0]       resp_data;
    logic              resp_err;
    logic              comp_start;
    logic              comp_busy;
    logic [31:0]       comp_code;
    logic              comp_done;
    logic              comp_stall;
    logic [31:0]       comp_returndata;
    logic [15:0]       stat_calls;
    logic [7:0]        stat_timeouts;
    logic [7:0]        stat_late;

    key_xlate_arbiter #(
        .N_REQ   (NR),
        .TIMEOUT (16)
    ) u_dut (
        .clock           (clock),
        .resetn          (resetn),
        .req_valid       (req_valid),
        .req_code        (req_code),
        .req_ready       (req_ready),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_data       (resp_data),
        .resp_err        (resp_err),
        .comp_start      (comp_start),
        .comp_busy       (comp_busy),
        .comp_code       (comp_code),
        .comp_done       (comp_done),
        .comp_stall      (comp_stall),
        .comp_returndata (comp_returndata),
        .stat_calls      (stat_calls),
        .stat_timeouts   (stat_timeouts),
        .stat_late       (stat_late)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          g;
        logic [31:0] d;
        logic        e;
    } exp_t;

    exp_t        sb[$];
    int          glog[$];
    int          gtime[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_ticks = 0;
    int          n_accept = 0;
    int          m_last = NR - 1;
    int          tr_lat = 1;
    int          tr_cnt = 0;
    bit          tr_never = 1'b0;
    bit          tr_pending = 1'b0;
    bit          tr_force = 1'b0;
    logic [31:0] tr_code = '0;
    logic [31:0] code_tb[NR];

    function automatic logic [31:0] xlate(input logic [31:0] c);
        return c ^ 32'h0000_003B;
    endfunction

    function automatic logic [NR-1:0] oh(input int g);
        logic [NR-1:0] v;
        v = '0;
        if (g >= 0 && g < NR) v[g[1:0]] = 1'b1;
        return v;
    endfunction

    function automatic int rr(input logic [NR-1:0] v, input int last);
        int i;
        for (int k = 1; k <= NR; k++) begin
            i = (last + k) % NR;
            if (v[i[1:0]]) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe handshakes that the coming edge will take, then advance to
    // the next falling edge and update the translator model and grant scoreboard.
    task automatic tick();
        exp_t e;
        int   g;
        if (comp_start && !comp_busy) begin
            tr_pending = 1'b1;
            tr_cnt     = tr_lat;
            tr_code    = comp_code;
            n_accept++;
        end
        if ((resp_valid & resp_ready) != '0) begin
            chk("sb_has_entry", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("resp_valid", 32'(resp_valid), 32'(oh(e.g)));
                chk("resp_data", resp_data, e.d);
                chk("resp_err", 32'(resp_err), 32'(e.e));
            end
        end
        @(negedge clock);
        n_ticks++;
        comp_done = 1'b0;
        if (!resetn) begin
            tr_pending = 1'b0;
        end else if (tr_force) begin
            comp_done       = 1'b1;
            comp_returndata = 32'hDEAD_BEEF;
            tr_force        = 1'b0;
        end else if (tr_pending && !tr_never) begin
            tr_cnt--;
            if (tr_cnt <= 0) begin
                comp_done       = 1'b1;
                comp_returndata = xlate(tr_code);
                tr_pending      = 1'b0;
            end
        end
        if (req_ready != '0) begin
            g = rr(req_valid, m_last);
            chk("grant", 32'(req_ready), 32'(oh(g)));
            glog.push_back(g);
            gtime.push_back(n_ticks);
            if (g >= 0) begin
                m_last = g;
                e.g = g;
                e.d = tr_never ? 32'd0 : xlate(code_tb[g]);
                e.e = tr_never;
                sb.push_back(e);
            end
        end
    endtask

    task automatic wait_resp();
        for (int i = 0; i < 64 && resp_valid == '0; i++) tick();
        chk("resp_seen", 32'(resp_valid != '0), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() > 0; i++) tick();
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        resetn     = 1'b0;
        req_valid  = '0;
        resp_ready = '0;
        comp_busy  = 1'b0;
        tick();
        tick();
        sb.delete();
        m_last     = NR - 1;
        tr_pending = 1'b0;
        tr_never   = 1'b0;
        resetn     = 1'b1;
    endtask

    int   wcnt;
    int   a0;
    logic seen;

    initial begin
        code_tb[0] = 32'h0000_0031;
        code_tb[1] = 32'h1234_5678;
        code_tb[2] = 32'hCAFE_0002;
        code_tb[3] = 32'h0000_0FF3;
        for (int i = 0; i < NR; i++) req_code[32*i +: 32] = code_tb[i];
        resetn          = 1'b0;
        req_valid       = '1;
        resp_ready      = '0;
        comp_busy       = 1'b0;
        comp_done       = 1'b0;
        comp_returndata = '0;

        // Reset values, with requests pending during reset
        tick();
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_comp_start", 32'(comp_start), 32'd0);
        chk("rst_comp_stall", 32'(comp_stall), 32'd1);
        chk("rst_comp_code", comp_code, 32'd0);
        chk("rst_stat_calls", 32'(stat_calls), 32'd0);
        chk("rst_stat_to", 32'(stat_timeouts), 32'd0);
        chk("rst_stat_late", 32'(stat_late), 32'd0);
        req_valid = '0;
        resetn    = 1'b1;
        tick();

        // Single call: code 0x31 -> 0x0A after 3 cycles, requester drops valid after ready
        req_valid = 4'b0001;
        tr_lat    = 3;
        tick();
        chk("t1_req_ready", 32'(req_ready), 32'h1);
        chk("t1_comp_start", 32'(comp_start), 32'd1);
        chk("t1_comp_code", comp_code, 32'h31);
        req_valid = '0;
        wait_resp();
        chk("t1_resp_valid", 32'(resp_valid), 32'h1);
        chk("t1_resp_data", resp_data, 32'h0A);
        chk("t1_resp_err", 32'(resp_err), 32'd0);
        chk("t1_stat_calls", 32'(stat_calls), 32'd1);
        resp_ready = 4'b0001;
        tick();
        resp_ready = '0;
        chk("t1_resp_clear", 32'(resp_valid), 32'd0);

        // Fair rotation with all requesters held
        do_reset();
        tick();
        glog.delete();
        gtime.delete();
        req_valid  = 4'b1111;
        resp_ready = 4'b1111;
        tr_lat     = 1;
        for (int i = 0; i < 200 && glog.size() < 8; i++) tick();
        req_valid = '0;
        chk("t2_ngrants", 32'(glog.size()), 32'd8);
        for (int i = 0; i < 8 && i < glog.size(); i++) chk("t2_order", 32'(glog[i]), 32'(i % 4));
        if (gtime.size() >= 2) chk("t2_turnaround", 32'(gtime[1] - gtime[0]), 32'd4);
        drain();
        chk("t2_stat_calls", 32'(stat_calls), 32'd8);

        // Translator stalls the call for 5 cycles
        resp_ready = '0;
        req_valid  = 4'b0010;
        comp_busy  = 1'b1;
        tr_lat     = 2;
        a0         = n_accept;
        tick();
        chk("t3_req_ready", 32'(req_ready), 32'h2);
        req_valid = '0;
        for (int i = 0; i < 5; i++) begin
            chk("t3_start_held", 32'(comp_start), 32'd1);
            chk("t3_code_stable", comp_code, code_tb[1]);
            tick();
        end
        comp_busy = 1'b0;
        chk("t3_start_6th", 32'(comp_start), 32'd1);
        chk("t3_code_6th", comp_code, code_tb[1]);
        tick();
        chk("t3_start_off", 32'(comp_start), 32'd0);
        resp_ready = 4'b0010;
        drain();
        chk("t3_one_call", 32'(n_accept - a0), 32'd1);
        chk("t3_stat_calls", 32'(stat_calls), 32'd9);

        // Translator never returns: timeout after 16 WAIT cycles, then a stray return
        resp_ready = '0;
        tr_never   = 1'b1;
        req_valid  = 4'b0100;
        tick();
        chk("t4_req_ready", 32'(req_ready), 32'h4);
        req_valid = '0;
        wcnt = 0;
        for (int i = 0; i < 40 && resp_valid == '0; i++) begin
            if (!comp_stall) wcnt++;
            tick();
        end
        chk("t4_wait_cycles", 32'(wcnt), 32'd16);
        chk("t4_resp_valid", 32'(resp_valid), 32'h4);
        chk("t4_resp_err", 32'(resp_err), 32'd1);
        chk("t4_resp_data", resp_data, 32'd0);
        chk("t4_stat_to", 32'(stat_timeouts), 32'd1);
        resp_ready = 4'b0100;
        tick();
        resp_ready = '0;
        tr_never   = 1'b0;
        tr_pending = 1'b0;
        tr_force   = 1'b1;
        tick();
        tick();
        chk("t4_stat_late", 32'(stat_late), 32'd1);
        chk("t4_stat_calls", 32'(stat_calls), 32'd9);

        // Response back-pressure for 10 cycles with another requester waiting
        req_valid = 4'b1001;
        tr_lat    = 1;
        tick();
        chk("t5_req_ready", 32'(req_ready), 32'h8);
        wait_resp();
        resp_ready = 4'b0111;
        for (int i = 0; i < 10; i++) begin
            chk("t5_valid_held", 32'(resp_valid), 32'h8);
            chk("t5_data_held", resp_data, xlate(code_tb[3]));
            chk("t5_no_grant", 32'(req_ready), 32'd0);
            tick();
        end
        resp_ready = 4'b1000;
        tick();
        tick();
        chk("t5_next_grant", 32'(req_ready), 32'h1);
        req_valid  = '0;
        resp_ready = 4'b1111;
        drain();
        chk("t5_stat_calls", 32'(stat_calls), 32'd11);

        // Reset while waiting on the translator
        resp_ready = '0;
        tr_never   = 1'b1;
        req_valid  = 4'b0001;
        tick();
        req_valid = '0;
        tick();
        tick();
        chk("t6_in_wait", 32'(comp_stall), 32'd0);
        resetn = 1'b0;
        #1;
        chk("t6_comp_stall", 32'(comp_stall), 32'd1);
        chk("t6_comp_start", 32'(comp_start), 32'd0);
        chk("t6_comp_code", comp_code, 32'd0);
        chk("t6_resp_valid", 32'(resp_valid), 32'd0);
        chk("t6_req_ready", 32'(req_ready), 32'd0);
        chk("t6_resp_data", resp_data, 32'd0);
        chk("t6_stat_calls", 32'(stat_calls), 32'd0);
        chk("t6_stat_to", 32'(stat_timeouts), 32'd0);
        chk("t6_stat_late", 32'(stat_late), 32'd0);
        tick();
        tick();
        sb.delete();
        m_last     = NR - 1;
        tr_pending = 1'b0;
        tr_never   = 1'b0;
        resetn     = 1'b1;
        resp_ready = '1;
        seen       = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (resp_valid != '0) seen = 1'b1;
            tick();
        end
        chk("t6_no_resp", 32'(seen), 32'd0);
        tr_force = 1'b1;
        tick();
        tick();
        chk("t6_late_after_rst", 32'(stat_late), 32'd1);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
